// File: rtl/riscv_pkg.sv
// Shared sizing constants for the RISC-V integer datapath.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int REGN = 32;
    localparam int REGW = $clog2(REGN);
    localparam logic [REGW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/riscv_regfile.sv
// Integer register file: one synchronous write port, whole array read out, x0 hardwired to zero.
module riscv_regfile
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [REGW-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata [0:REGN-1]
);

    // x0 has no storage; only x1..x(REGN-1) are flops.
    logic [XLEN-1:0] mem [1:REGN-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < REGN; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata[0] = '0;
        for (int i = 1; i < REGN; i++) begin
            rdata[i] = mem[i];
        end
    end

endmodule

// File: rtl/riscv_wb.sv
// Write-back stage: picks execute or load result and commits it to the register file.
module riscv_wb
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] exdata,
    input  logic [XLEN-1:0] memdata,
    input  logic            memfeth,
    input  logic [REGW-1:0] rd,
    output logic [XLEN-1:0] regs [0:REGN-1],
    output logic            wr_on_zero
);

    logic [XLEN-1:0] wdata_p0;
    logic            we_p0;

    // Stage p0: source select and write enable; bubbles arrive as rd == x0.
    always_comb begin
        wdata_p0 = memfeth ? memdata : exdata;
        we_p0    = (rd != REG_ZERO);
    end

    riscv_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we_p0),
        .waddr (rd),
        .wdata (wdata_p0),
        .rdata (regs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_on_zero <= 1'b0;
        end else begin
            wr_on_zero <= ~we_p0;
        end
    end

endmodule

// File: tb/tb_riscv_wb.sv
// Self-checking bench for riscv_wb: vector table plus randomised traffic against a register model.
module tb_riscv_wb;

    localparam int XLEN = 32;
    localparam int REGN = 32;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] exdata;
    logic [XLEN-1:0] memdata;
    logic            memfeth;
    logic [4:0]      rd;
    logic [XLEN-1:0] regs [0:REGN-1];
    logic            wr_on_zero;

    riscv_wb dut (
        .clk        (clk),
        .rst        (rst),
        .exdata     (exdata),
        .memdata    (memdata),
        .memfeth    (memfeth),
        .rd         (rd),
        .regs       (regs),
        .wr_on_zero (wr_on_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic            rst;
        logic            memfeth;
        logic [XLEN-1:0] exdata;
        logic [XLEN-1:0] memdata;
        logic [4:0]      rd;
        int              chk_idx;
        logic [XLEN-1:0] chk_val;
        logic            exp_woz;
    } vec_t;

    typedef struct packed {
        logic [REGN-1:0][XLEN-1:0] r;
        logic                      woz;
    } exp_t;

    exp_t            sb [$];
    logic [XLEN-1:0] model [0:REGN-1];
    logic            model_woz;
    int              n_tests;
    int              n_fail;
    vec_t            tbl [$];

    function automatic vec_t mk(string name, logic r, logic mf, logic [XLEN-1:0] ex,
                                logic [XLEN-1:0] md, logic [4:0] d, int idx,
                                logic [XLEN-1:0] val, logic woz);
        vec_t v;
        v.name = name; v.rst = r; v.memfeth = mf; v.exdata = ex; v.memdata = md;
        v.rd = d; v.chk_idx = idx; v.chk_val = val; v.exp_woz = woz;
        return v;
    endfunction

    // Drive one cycle of inputs, update the model and queue the expected post-edge state.
    task automatic drive(input logic r, input logic mf, input logic [XLEN-1:0] ex,
                         input logic [XLEN-1:0] md, input logic [4:0] d);
        exp_t e;
        @(negedge clk);
        rst = r; memfeth = mf; exdata = ex; memdata = md; rd = d;
        if (r) begin
            for (int i = 0; i < REGN; i++) model[i] = '0;
            model_woz = 1'b0;
        end else if (d != 5'd0) begin
            model[d] = mf ? md : ex;
            model_woz = 1'b0;
        end else begin
            model_woz = 1'b1;
        end
        for (int i = 0; i < REGN; i++) e.r[i] = model[i];
        e.woz = model_woz;
        sb.push_back(e);
    endtask

    task automatic check_sb(input string name);
        exp_t e;
        int   bad;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        bad = -1;
        for (int i = REGN - 1; i >= 0; i--) begin
            if (regs[i] !== e.r[i]) bad = i;
        end
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s regs[%0d]: got %h expected %h", name, bad, regs[bad], e.r[bad]);
        end
        n_tests++;
        if (wr_on_zero !== e.woz) begin
            n_fail++;
            $display("FAIL %s wr_on_zero: got %b expected %b", name, wr_on_zero, e.woz);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        drive(v.rst, v.memfeth, v.exdata, v.memdata, v.rd);
        check_sb(v.name);
        n_tests++;
        if (regs[v.chk_idx] !== v.chk_val || wr_on_zero !== v.exp_woz) begin
            n_fail++;
            $display("FAIL %s direct: regs[%0d]=%h woz=%b expected %h woz=%b", v.name,
                     v.chk_idx, regs[v.chk_idx], wr_on_zero, v.chk_val, v.exp_woz);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; memfeth = 1'b0; exdata = '0; memdata = '0; rd = '0;
        for (int i = 0; i < REGN; i++) model[i] = '0;
        model_woz = 1'b0;

        tbl.push_back(mk("reset",       1, 0, 32'hA5A5A5A5, 32'h0,        5'd4,  4,  32'h0,        0));
        tbl.push_back(mk("ex_write",    0, 0, 32'hDEADBEEF, 32'h12345678, 5'd5,  5,  32'hDEADBEEF, 0));
        tbl.push_back(mk("load_write",  0, 1, 32'h11111111, 32'hCAFEF00D, 5'd31, 31, 32'hCAFEF00D, 0));
        tbl.push_back(mk("x0_target",   0, 0, 32'hFFFFFFFF, 32'h0,        5'd0,  0,  32'h0,        1));
        tbl.push_back(mk("x5_kept",     0, 0, 32'h00000007, 32'h0,        5'd3,  5,  32'hDEADBEEF, 0));
        tbl.push_back(mk("b2b_1",       0, 0, 32'h00000001, 32'h0,        5'd10, 10, 32'h1,        0));
        tbl.push_back(mk("b2b_2",       0, 0, 32'h00000002, 32'h0,        5'd10, 10, 32'h2,        0));
        tbl.push_back(mk("b2b_3",       0, 1, 32'h00000099, 32'h00000003, 5'd10, 10, 32'h3,        0));
        tbl.push_back(mk("bubble",      0, 1, 32'h0,        32'h00000055, 5'd0,  10, 32'h3,        1));
        tbl.push_back(mk("rst_pending", 1, 0, 32'hA5A5A5A5, 32'h0,        5'd4,  4,  32'h0,        0));
        tbl.push_back(mk("rst_x31",     0, 0, 32'h00000000, 32'h0,        5'd0,  31, 32'h0,        1));
        tbl.push_back(mk("resume",      0, 0, 32'hA5A5A5A5, 32'h0,        5'd4,  4,  32'hA5A5A5A5, 0));
        tbl.push_back(mk("memdata_x",   0, 0, 32'h0BADF00D, 'x,           5'd6,  6,  32'h0BADF00D, 0));
        tbl.push_back(mk("exdata_x",    0, 1, 'x,           32'h600DCAFE, 5'd7,  7,  32'h600DCAFE, 0));

        for (int k = 0; k < tbl.size(); k++) apply_vec(tbl[k]);

        // x3 written earlier must be cleared by the mid-stream reset and stay clear.
        n_tests++;
        if (regs[3] !== 32'h0) begin
            n_fail++;
            $display("FAIL x3_after_reset: got %h expected 00000000", regs[3]);
        end

        for (int k = 0; k < 200; k++) begin
            logic            r;
            logic            mf;
            logic [4:0]      d;
            r  = ($urandom_range(0, 39) == 0);
            mf = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            drive(r, mf, $urandom, $urandom, d);
            check_sb("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_wb.md
Name:
riscv_wb

Overview:
- Write-back stage of the in-order RISC-V pipeline.
- Selects the instruction result from one of two sources: the execute-stage result, or data loaded from memory.
- Commits that result into the architectural integer register file, which this block owns.
- Exposes the whole register file as an output for decode-stage operand reads and for debug, and flags attempted writes to x0.

Parameters:
- XLEN, 32, register and data width in bits.
- REGN, 32, number of architectural integer registers. Register index width is log2(REGN) = 5.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- exdata  input  XLEN  result from the execute stage (ALU result, link address, LUI/AUIPC value).
- memdata  input  XLEN  load data from the memory stage, already sign- or zero-extended.
- memfeth  input  1  source select: 1 selects memdata (load), 0 selects exdata.
- rd  input  5  destination register index. Index 0 means no architectural write.
- regs  output  array [0:REGN-1] of XLEN  current register file contents, driven directly from the storage flops.
- wr_on_zero  output  1  registered flag: the last committed cycle targeted x0.

Behaviour:
- Write data is formed combinationally: wdata = memfeth ? memdata : exdata.
- On each rising edge of clk with rst=1:
  - every entry regs[0..REGN-1] becomes 0;
  - wr_on_zero becomes 0;
  - the data inputs are ignored.
- On each rising edge of clk with rst=0 and rd!=0:
  - regs[rd] <= wdata;
  - all other entries hold;
  - wr_on_zero <= 0.
- On each rising edge of clk with rst=0 and rd==0:
  - no entry changes;
  - wr_on_zero <= 1.
- Bubbles and stalls are presented as rd=0, so no separate write enable exists.
- regs[0] reads as 0 at all times, including after reset and after any write attempt. It is tied to zero, not stored.
- Write latency is one cycle: new data is visible on regs in the cycle after the edge that commits it. There is no internal write-to-read bypass; forwarding is the job of decode and hazard logic.
- Consecutive writes to the same rd: the last committed value wins, and each edge overwrites.
- rst has priority over any write presented in the same cycle. Reset mid-stream discards the pending write.
- Outputs after power-up, before the first reset, are undefined. Only the post-reset values are specified.
- No X-propagation from memdata when memfeth=0, and none from exdata when memfeth=1.

Decomposition:
- Shared package riscv_pkg holds XLEN, REGN, the register index width, and the localparam REG_ZERO=0.
- One sub-module is natural: riscv_regfile.
  - It is a single write port (we, waddr, wdata) with the full array exposed as a read-out, and x0 hardwired to zero.
  - riscv_wb adds the source mux, the rd!=0 enable and the wr_on_zero flag around it.

Test Plan:
- Reset: drive rst=1 for one edge.
  -> All regs[0..31]=0 and wr_on_zero=0.
- Execute write: memfeth=0, exdata=32'hDEADBEEF, memdata=32'h12345678, rd=5, one edge.
  -> regs[5]=32'hDEADBEEF, all other regs unchanged, wr_on_zero=0.
- Load write: memfeth=1, exdata=32'h11111111, memdata=32'hCAFEF00D, rd=31, one edge.
  -> regs[31]=32'hCAFEF00D and regs[5] still 32'hDEADBEEF.
- x0 target: rd=0, exdata=32'hFFFFFFFF, memfeth=0, one edge.
  -> regs[0]=0, no other register changed, wr_on_zero=1.
  - Next edge with rd=3, exdata=7:
    -> regs[3]=7 and wr_on_zero=0.
- Back-to-back writes: rd=10 with exdata=1, then exdata=2, then memfeth=1 with memdata=3 on consecutive edges.
  -> regs[10] reads 1, then 2, then 3 after each edge.
- Reset with pending write: registers preloaded, then rst=1 together with rd=4 and exdata=32'hA5A5A5A5.
  -> After the edge, all regs=0, including regs[4], and wr_on_zero=0.
  - With rst=0 on the following edge:
    -> Normal writes resume.
